// File: rtl/daq_acq_sequencer.sv
// ---------------------------------------------------------------------------
// daq_acq_sequencer
//
// Purpose:
//   Sequences power-up, ASIC reset, acquisition, readout and end-hold for a
//   daisy-chain of NUM_ASIC front-end ASICs. It supports external-trigger or
//   auto-run acquisition. It captures which ASICs were saturated, counts
//   completed acquisitions, and forces a readout if the chain never signals
//   read-start (watchdog).
//
// Configuration macro:
//   POWER_PULSING_EN - when defined, the analog/DAC and digital supplies are
//                      pulsed per phase. When undefined, all three supplies
//                      follow Busy.
//
// Ports:
//   Clk, reset_n       system clock, asynchronous active-low reset
//   ModuleStart        run enable (level)
//   AcqMode            0 = external trigger on AcqStart, 1 = auto-run
//   AcqStart           external trigger (async, rising edge)
//   EndReadout         readout RAM done (async, falling edge = done)
//   CHIPSATB           per-ASIC full flags (async, active-low)
//   AcquisitionTime    acquisition window length in cycles (0 acts as 1)
//   EndHoldTime        idle cycles after each readout
//   RESET_B            ASIC digital reset, active-low
//   START_ACQ          acquisition window, active-high
//   StartReadout       readout start pulse, T_SRO cycles wide
//   PWR_ON_A/D/DAC     power-pulsing controls; PWR_ON_ADC is tied low
//   OnceEnd            1-cycle pulse per completed acquisition
//   SatMask            ASICs saturated in the last acquisition (1 = full)
//   AcqCount           completed acquisitions since the run started
//   ReadTimeoutErr     sticky watchdog flag, cleared when a run starts
//   Busy               high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module daq_acq_sequencer #(
  parameter int NUM_ASIC      = 4,
  parameter int CNT_W         = 16,
  parameter int T_PWR_RESET   = 8,
  parameter int T_RESET_START = 40,
  parameter int T_SRO         = 16,
  parameter int T_READ_TO     = 4096
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                ModuleStart,
  input  logic                AcqMode,
  input  logic                AcqStart,
  input  logic                EndReadout,
  input  logic [NUM_ASIC-1:0] CHIPSATB,
  input  logic [CNT_W-1:0]    AcquisitionTime,
  input  logic [CNT_W-1:0]    EndHoldTime,
  output logic                RESET_B,
  output logic                START_ACQ,
  output logic                StartReadout,
  output logic                PWR_ON_A,
  output logic                PWR_ON_D,
  output logic                PWR_ON_DAC,
  output logic                PWR_ON_ADC,
  output logic                OnceEnd,
  output logic [NUM_ASIC-1:0] SatMask,
  output logic [31:0]         AcqCount,
  output logic                ReadTimeoutErr,
  output logic                Busy
);

  typedef enum logic [3:0] {
    IDLE,
    CHIP_RESET,
    POWER_WAIT,
    RELEASE,
    WAIT_START,
    ACQ,
    WAIT_READ,
    START_READOUT,
    WAIT_READ_DONE,
    ONCE_END,
    ALL_DONE
  } state_t;

  // Last counter value of each fixed-length state. The counter starts at 0
  // on the first cycle of a state.
  localparam logic [CNT_W-1:0] C_PWR_LAST   = CNT_W'(T_PWR_RESET);
  localparam logic [CNT_W-1:0] C_REL_LAST   = CNT_W'(T_RESET_START);
  localparam logic [CNT_W-1:0] C_SRO_LAST   = CNT_W'(T_SRO - 1);
  localparam logic [CNT_W-1:0] C_RDTO_LAST  = CNT_W'(T_READ_TO - 1);

  state_t r_state;
  state_t w_nextState;
  logic   w_timeout;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_acqStartMeta, r_acqStartSync, r_acqStartPrev;
  logic                r_endRdMeta, r_endRdSync, r_endRdPrev;
  logic [NUM_ASIC-1:0] r_satMeta, r_satSync;
  logic                r_satAllPrev;

  logic                r_resetB, r_startAcq, r_startReadout, r_onceEnd, r_busy;
  logic                r_pwrA, r_pwrD, r_readTimeoutErr;
  logic [NUM_ASIC-1:0] r_satMask;
  logic [31:0]         r_acqCount;

  logic                w_satAll, w_chipFull, w_readStart;
  logic                w_acqStartEdge, w_endRead;
  logic [CNT_W-1:0]    w_acqLen;
  logic                w_acqLast, w_holdLast;

  // Two-flop synchronisers for every asynchronous input, plus one extra
  // stage that holds the previous synchronised value for edge detection.
  // Everything resets to the inactive level so that no false edge appears
  // when reset is released.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acqStartMeta <= 1'b0;
      r_acqStartSync <= 1'b0;
      r_acqStartPrev <= 1'b0;
      r_endRdMeta    <= 1'b0;
      r_endRdSync    <= 1'b0;
      r_endRdPrev    <= 1'b0;
      r_satMeta      <= '1;
      r_satSync      <= '1;
      r_satAllPrev   <= 1'b1;
    end else begin
      r_acqStartMeta <= AcqStart;
      r_acqStartSync <= r_acqStartMeta;
      r_acqStartPrev <= r_acqStartSync;
      r_endRdMeta    <= EndReadout;
      r_endRdSync    <= r_endRdMeta;
      r_endRdPrev    <= r_endRdSync;
      r_satMeta      <= CHIPSATB;
      r_satSync      <= r_satMeta;
      r_satAllPrev   <= w_satAll;
    end
  end

  // Decode the events from the synchronised inputs. A saturated ASIC pulls
  // its flag low, so the chain is "full" when any flag drops. It is ready for
  // readout once every flag is high again.
  assign w_satAll       = &r_satSync;
  assign w_chipFull     = r_satAllPrev & ~w_satAll;
  assign w_readStart    = ~r_satAllPrev & w_satAll;
  assign w_acqStartEdge = r_acqStartSync & ~r_acqStartPrev;
  assign w_endRead      = r_endRdPrev & ~r_endRdSync;

  // A zero acquisition time still yields a one-cycle window. A zero
  // end-hold passes through ONCE_END in its single mandatory cycle.
  assign w_acqLen   = (AcquisitionTime == '0) ? CNT_W'(1) : AcquisitionTime;
  assign w_acqLast  = (r_cnt >= (w_acqLen - CNT_W'(1)));
  assign w_holdLast = (EndHoldTime == '0) || (r_cnt >= (EndHoldTime - CNT_W'(1)));

  // State register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. ModuleStart is only examined in IDLE and WAIT_START.
  // A run that is switched off mid-acquisition therefore finishes its
  // current readout first.
  always_comb begin
    w_nextState = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:           if (ModuleStart) w_nextState = CHIP_RESET;
      CHIP_RESET:     w_nextState = POWER_WAIT;
      POWER_WAIT:     if (r_cnt >= C_PWR_LAST) w_nextState = RELEASE;
      RELEASE:        if (r_cnt >= C_REL_LAST) w_nextState = WAIT_START;
      WAIT_START: begin
        if (!ModuleStart)                  w_nextState = ALL_DONE;
        else if (AcqMode)                  w_nextState = ACQ;
        else if (w_acqStartEdge)           w_nextState = ACQ;
      end
      ACQ: begin
        if (w_chipFull)                    w_nextState = WAIT_READ;
        else if (w_acqLast)                w_nextState = START_READOUT;
      end
      WAIT_READ: begin
        if (w_readStart) begin
          w_nextState = START_READOUT;
        end else if (r_cnt >= C_RDTO_LAST) begin
          w_nextState = START_READOUT;
          w_timeout   = 1'b1;
        end
      end
      START_READOUT:  if (r_cnt >= C_SRO_LAST) w_nextState = WAIT_READ_DONE;
      WAIT_READ_DONE: if (w_endRead) w_nextState = ONCE_END;
      ONCE_END:       if (w_holdLast) w_nextState = WAIT_START;
      ALL_DONE:       w_nextState = IDLE;
      default:        w_nextState = IDLE;
    endcase
  end

  // Per-state cycle counter. It restarts on every state change and
  // saturates rather than wrapping.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_nextState != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output registers. Outputs are decoded from the next state so that they
  // change on the same edge as the state register and never glitch.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resetB         <= 1'b1;
      r_startAcq       <= 1'b0;
      r_startReadout   <= 1'b0;
      r_onceEnd        <= 1'b0;
      r_busy           <= 1'b0;
      r_pwrA           <= 1'b0;
      r_pwrD           <= 1'b0;
      r_satMask        <= '0;
      r_acqCount       <= '0;
      r_readTimeoutErr <= 1'b0;
    end else begin
      r_resetB       <= !((w_nextState == CHIP_RESET) || (w_nextState == POWER_WAIT));
      r_startAcq     <= (w_nextState == ACQ);
      r_startReadout <= (w_nextState == START_READOUT);
      r_busy         <= (w_nextState != IDLE);
      r_onceEnd      <= (r_state == WAIT_READ_DONE) && (w_nextState == ONCE_END);
`ifdef POWER_PULSING_EN
      r_pwrD <= w_nextState inside {ACQ, WAIT_READ, START_READOUT, WAIT_READ_DONE, ONCE_END};
      r_pwrA <= w_nextState inside {POWER_WAIT, RELEASE, WAIT_START, ACQ};
`else
      r_pwrD <= (w_nextState != IDLE);
      r_pwrA <= (w_nextState != IDLE);
`endif
      if ((r_state == ACQ) && (w_nextState != ACQ)) begin
        r_satMask <= ~r_satSync;
      end
      if ((r_state == IDLE) && (w_nextState == CHIP_RESET)) begin
        r_acqCount       <= '0;
        r_readTimeoutErr <= 1'b0;
      end else begin
        if ((r_state == WAIT_READ_DONE) && (w_nextState == ONCE_END)) begin
          r_acqCount <= r_acqCount + 32'd1;
        end
        if (w_timeout) begin
          r_readTimeoutErr <= 1'b1;
        end
      end
    end
  end

  assign RESET_B        = r_resetB;
  assign START_ACQ      = r_startAcq;
  assign StartReadout   = r_startReadout;
  assign OnceEnd        = r_onceEnd;
  assign Busy           = r_busy;
  assign PWR_ON_A       = r_pwrA;
  assign PWR_ON_DAC     = r_pwrA;
  assign PWR_ON_D       = r_pwrD;
  assign PWR_ON_ADC     = 1'b0;
  assign SatMask        = r_satMask;
  assign AcqCount       = r_acqCount;
  assign ReadTimeoutErr = r_readTimeoutErr;

endmodule

// File: tb/tb_daq_acq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_daq_acq_sequencer
//
// Purpose:
//   Directed, self-checking bench for daq_acq_sequencer with its default
//   parameters (4 ASICs, 16-bit counters, T_SRO = 16, T_READ_TO = 4096).
//   A table of external-trigger acquisitions is followed by hand-written
//   sequences for saturation, watchdog, auto-run, run stop and async reset.
// ---------------------------------------------------------------------------
module tb_daq_acq_sequencer;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        ModuleStart, AcqMode, AcqStart, EndReadout;
  logic [3:0]  CHIPSATB;
  logic [15:0] AcquisitionTime, EndHoldTime;
  logic        RESET_B, START_ACQ, StartReadout;
  logic        PWR_ON_A, PWR_ON_D, PWR_ON_DAC, PWR_ON_ADC;
  logic        OnceEnd, ReadTimeoutErr, Busy;
  logic [3:0]  SatMask;
  logic [31:0] AcqCount;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    int acqTime;
    int endHold;
    int expAcqW;
    int expCount;
  } vec_t;

  vec_t vecs[4];

  localparam int S_ACQ = 0, S_SRO = 1, S_ONCE = 2, S_BUSY = 3, S_RSTB = 4;

  daq_acq_sequencer dut (
    .Clk(Clk), .reset_n(reset_n), .ModuleStart(ModuleStart), .AcqMode(AcqMode),
    .AcqStart(AcqStart), .EndReadout(EndReadout), .CHIPSATB(CHIPSATB),
    .AcquisitionTime(AcquisitionTime), .EndHoldTime(EndHoldTime),
    .RESET_B(RESET_B), .START_ACQ(START_ACQ), .StartReadout(StartReadout),
    .PWR_ON_A(PWR_ON_A), .PWR_ON_D(PWR_ON_D), .PWR_ON_DAC(PWR_ON_DAC),
    .PWR_ON_ADC(PWR_ON_ADC), .OnceEnd(OnceEnd), .SatMask(SatMask),
    .AcqCount(AcqCount), .ReadTimeoutErr(ReadTimeoutErr), .Busy(Busy)
  );

  // 100 MHz clock.
  always #5 Clk = ~Clk;

  // Hard stop in case a sequence wedges the simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      S_ACQ:   return START_ACQ;
      S_SRO:   return StartReadout;
      S_ONCE:  return OnceEnd;
      S_BUSY:  return Busy;
      default: return RESET_B;
    endcase
  endfunction

  // Ticks until the selected output reaches level. n = ticks taken, or -1
  // if the budget expired.
  task automatic waitLevel(input int sel, input logic level, input int budget, output int n);
    n = 0;
    while (sigVal(sel) !== level && n < budget) begin
      tick();
      n++;
    end
    if (sigVal(sel) !== level) n = -1;
  endtask

  // Waits for the level, then counts how many cycles it is held.
  task automatic measureWidth(input int sel, input logic level, input int budget, output int w);
    int n;
    waitLevel(sel, level, budget, n);
    w = 0;
    if (n < 0) begin
      w = -1;
    end else begin
      while (sigVal(sel) === level && w < budget) begin
        tick();
        w++;
      end
    end
  endtask

  // Raises ModuleStart and checks the ASIC reset pulse (CHIP_RESET 1 cycle
  // plus POWER_WAIT 9 cycles). Returns in the first RELEASE cycle.
  task automatic startRun(input logic mode);
    int w;
    AcqMode     = mode;
    ModuleStart = 1'b1;
    measureWidth(S_RSTB, 1'b0, 10, w);
    checkOutput("resetBLowWidth", w, 10);
    checkOutput("busyInRun", Busy, 1);
  endtask

  // One externally triggered acquisition from the table, without saturation.
  task automatic applyStimulus(input vec_t v, input int idx);
    int w;
    AcquisitionTime = 16'(v.acqTime);
    EndHoldTime     = 16'(v.endHold);
    EndReadout      = 1'b1;
    ticks(3);
    AcqStart = 1'b1;
    measureWidth(S_ACQ, 1'b1, 300, w);
    AcqStart = 1'b0;
    checkOutput($sformatf("acqWidth[%0d]", idx), w, v.expAcqW);
    measureWidth(S_SRO, 1'b1, 40, w);
    checkOutput($sformatf("sroWidth[%0d]", idx), w, 16);
    EndReadout = 1'b0;
    measureWidth(S_ONCE, 1'b1, 10, w);
    checkOutput($sformatf("onceEndWidth[%0d]", idx), w, 1);
    checkOutput($sformatf("acqCount[%0d]", idx), AcqCount, v.expCount);
    checkOutput($sformatf("satMask[%0d]", idx), SatMask, 0);
    ticks(v.endHold + 3);
  endtask

  initial begin
    int n, w;

    vecs[0] = '{acqTime: 100, endHold: 0, expAcqW: 100, expCount: 1};
    vecs[1] = '{acqTime: 0,   endHold: 3, expAcqW: 1,   expCount: 2};
    vecs[2] = '{acqTime: 1,   endHold: 0, expAcqW: 1,   expCount: 3};
    vecs[3] = '{acqTime: 37,  endHold: 5, expAcqW: 37,  expCount: 4};

    reset_n = 1'b0; ModuleStart = 1'b0; AcqMode = 1'b0; AcqStart = 1'b0;
    EndReadout = 1'b0; CHIPSATB = 4'hF; AcquisitionTime = 16'd100; EndHoldTime = 16'd0;
    #23;
    checkOutput("rstResetB", RESET_B, 1);
    checkOutput("rstStartAcq", START_ACQ, 0);
    checkOutput("rstBusy", Busy, 0);
    reset_n = 1'b1;
    ticks(3);
    checkOutput("idleStartReadout", StartReadout, 0);
    checkOutput("idleAcqCount", AcqCount, 0);
    checkOutput("idlePwrOnA", PWR_ON_A, 0);
    checkOutput("idleSatMask", SatMask, 0);

    // External-trigger run, table-driven acquisitions.
    startRun(1'b0);
    ticks(45);
    checkOutput("noAutoStart", START_ACQ, 0);
    checkOutput("pwrOnARun", PWR_ON_A, 1);
    checkOutput("pwrOnDacRun", PWR_ON_DAC, 1);
    checkOutput("pwrOnAdcTied", PWR_ON_ADC, 0);
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Saturation on ASIC 2 at cycle 30 of the window, released 20 cycles later.
    AcquisitionTime = 16'd200;
    EndReadout = 1'b1;
    AcqStart = 1'b1;
    waitLevel(S_ACQ, 1'b1, 10, n);
    AcqStart = 1'b0;
    ticks(30);
    CHIPSATB = 4'b1011;
    waitLevel(S_ACQ, 1'b0, 10, n);
    checkOutput("satDropLatency", n, 3);
    checkOutput("satMaskAsic2", SatMask, 4'b0100);
    checkOutput("satNoReadoutYet", StartReadout, 0);
    ticks(20);
    CHIPSATB = 4'hF;
    waitLevel(S_SRO, 1'b1, 10, n);
    checkOutput("satReleaseLatency", n, 3);
    measureWidth(S_SRO, 1'b1, 40, w);
    checkOutput("satSroWidth", w, 16);
    EndReadout = 1'b0;
    measureWidth(S_ONCE, 1'b1, 10, w);
    checkOutput("satOnceEnd", w, 1);
    checkOutput("satCount", AcqCount, 5);
    checkOutput("satNoTimeout", ReadTimeoutErr, 0);
    ticks(8);

    // Saturation on ASIC 3 never released: watchdog forces the readout.
    EndReadout = 1'b1;
    AcqStart = 1'b1;
    waitLevel(S_ACQ, 1'b1, 10, n);
    AcqStart = 1'b0;
    ticks(10);
    CHIPSATB = 4'b0111;
    waitLevel(S_ACQ, 1'b0, 10, n);
    waitLevel(S_SRO, 1'b1, 5000, n);
    checkOutput("timeoutCycles", n, 4096);
    checkOutput("timeoutErrSet", ReadTimeoutErr, 1);
    checkOutput("timeoutSatMask", SatMask, 4'b1000);
    measureWidth(S_SRO, 1'b1, 40, w);
    checkOutput("timeoutSroWidth", w, 16);
    EndReadout = 1'b0;
    measureWidth(S_ONCE, 1'b1, 10, w);
    checkOutput("timeoutOnceEnd", w, 1);
    checkOutput("timeoutCount", AcqCount, 6);
    CHIPSATB = 4'hF;
    ticks(8);

    // Stop the run from WAIT_START: ALL_DONE then IDLE.
    ModuleStart = 1'b0;
    waitLevel(S_BUSY, 1'b0, 20, n);
    checkOutput("stopLatency", n, 2);
    checkOutput("errSticky", ReadTimeoutErr, 1);

    // Auto-run: five back-to-back acquisitions, no trigger.
    AcquisitionTime = 16'd20;
    EndHoldTime     = 16'd10;
    EndReadout      = 1'b1;
    startRun(1'b1);
    checkOutput("errClearedOnStart", ReadTimeoutErr, 0);
    checkOutput("countClearedOnStart", AcqCount, 0);
    for (int k = 0; k < 5; k++) begin
      measureWidth(S_ACQ, 1'b1, 80, w);
      checkOutput($sformatf("autoAcqWidth[%0d]", k), w, 20);
      measureWidth(S_SRO, 1'b1, 40, w);
      checkOutput($sformatf("autoSroWidth[%0d]", k), w, 16);
      EndReadout = 1'b0;
      measureWidth(S_ONCE, 1'b1, 10, w);
      checkOutput($sformatf("autoOnceEnd[%0d]", k), w, 1);
      EndReadout = 1'b1;
      waitLevel(S_ACQ, 1'b1, 30, n);
      checkOutput($sformatf("autoGap[%0d]", k), n, 10);
    end
    checkOutput("autoCount", AcqCount, 5);

    // ModuleStart dropped during the sixth window: readout still completes.
    ModuleStart = 1'b0;
    measureWidth(S_ACQ, 1'b1, 80, w);
    checkOutput("dropAcqWidth", w, 20);
    measureWidth(S_SRO, 1'b1, 40, w);
    checkOutput("dropSroWidth", w, 16);
    EndReadout = 1'b0;
    measureWidth(S_ONCE, 1'b1, 10, w);
    checkOutput("dropOnceEnd", w, 1);
    EndReadout = 1'b1;
    waitLevel(S_BUSY, 1'b0, 40, n);
    checkOutput("dropBusyLatency", n, 11);
    checkOutput("dropCount", AcqCount, 6);
    checkOutput("dropNoNewAcq", START_ACQ, 0);
    checkOutput("dropPwrOnD", PWR_ON_D, 0);

    // Async reset in the middle of a readout pulse.
    startRun(1'b1);
    waitLevel(S_SRO, 1'b1, 100, n);
    checkOutput("preResetSro", StartReadout, 1);
    ticks(3);
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstSro", StartReadout, 0);
    checkOutput("asyncRstResetB", RESET_B, 1);
    checkOutput("asyncRstBusy", Busy, 0);
    checkOutput("asyncRstCount", AcqCount, 0);
    checkOutput("asyncRstPwrOnA", PWR_ON_A, 0);
    ModuleStart = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    checkOutput("postRstIdle", Busy, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
